// File: rtl/bus_pkg.sv
// Shared definitions for the bus source-select decoder: source codes, FSM states and
// a code range check.
package bus_pkg;

  localparam int NUM_SRC = 24;
  localparam int CODE_W  = 5;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t CODE_COUT      = 5'd0;
  localparam code_t CODE_INPORTOUT = 5'd1;
  localparam code_t CODE_MDROUT    = 5'd2;
  localparam code_t CODE_PCOUT     = 5'd3;
  localparam code_t CODE_ZLOWOUT   = 5'd4;
  localparam code_t CODE_ZHIGHOUT  = 5'd5;
  localparam code_t CODE_LOOUT     = 5'd6;
  localparam code_t CODE_HIOUT     = 5'd7;
  // General registers are numbered in reverse: code 23-n selects Rn.
  localparam code_t CODE_R15       = 5'd8;
  localparam code_t CODE_R14       = 5'd9;
  localparam code_t CODE_R13       = 5'd10;
  localparam code_t CODE_R12       = 5'd11;
  localparam code_t CODE_R11       = 5'd12;
  localparam code_t CODE_R10       = 5'd13;
  localparam code_t CODE_R9        = 5'd14;
  localparam code_t CODE_R8        = 5'd15;
  localparam code_t CODE_R7        = 5'd16;
  localparam code_t CODE_R6        = 5'd17;
  localparam code_t CODE_R5        = 5'd18;
  localparam code_t CODE_R4        = 5'd19;
  localparam code_t CODE_R3        = 5'd20;
  localparam code_t CODE_R2        = 5'd21;
  localparam code_t CODE_R1        = 5'd22;
  localparam code_t CODE_R0        = 5'd23;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StGap   = 2'd2
  } bus_state_e;

  function automatic logic code_valid(code_t code);
    return code < CODE_W'(NUM_SRC);
  endfunction

endpackage

// File: rtl/onehot24_dec.sv
// Expands a 5-bit source code into a 24-bit one-hot enable; out-of-range codes give zero.
module onehot24_dec
  import bus_pkg::*;
(
  input  logic [CODE_W-1:0]  code,
  output logic [NUM_SRC-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (code == CODE_W'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_dec.sv
// Bus source-select decoder: one registered one-hot drive enable, with a one-cycle
// break-before-make gap whenever the driving source changes.
module bus_dec
  import bus_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               sel_valid,
  input  logic [CODE_W-1:0]  sel,
  input  logic               err_clr,
  output logic [NUM_SRC-1:0] out_en,
  output logic [CODE_W-1:0]  active_code,
  output logic               drive,
  output logic               busy,
  output logic               sel_err
);

  bus_state_e         state_q, state_d;
  code_t              code_d;
  code_t              pending_q, pending_d;
  logic               err_d;
  logic               sel_ok;
  logic [NUM_SRC-1:0] onehot_d;
  logic [NUM_SRC-1:0] out_en_d;

  always_comb begin
    sel_ok    = code_valid(sel);
    state_d   = state_q;
    code_d    = active_code;
    pending_d = pending_q;

    case (state_q)
      StIdle: begin
        if (sel_valid && sel_ok) begin
          state_d = StDrive;
          code_d  = sel;
        end
      end
      StDrive: begin
        if (!sel_valid || !sel_ok) begin
          state_d = StIdle;
        end else if (sel != active_code) begin
          state_d   = StGap;
          pending_d = sel;
        end
      end
      StGap: begin
        // Last request seen during the gap wins; an idle or bad request drops it.
        if (sel_valid && sel_ok) begin
          pending_d = sel;
          code_d    = pending_d;
          state_d   = StDrive;
        end else begin
          pending_d = '0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (sel_valid && !sel_ok) err_d = 1'b1;
    else if (err_clr)         err_d = 1'b0;
    else                      err_d = sel_err;
  end

  onehot24_dec u_onehot (
    .code   (code_d),
    .onehot (onehot_d)
  );

  assign out_en_d = (state_d == StDrive) ? onehot_d : '0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      active_code <= '0;
      out_en      <= '0;
      drive       <= 1'b0;
      busy        <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      active_code <= code_d;
      out_en      <= out_en_d;
      drive       <= (state_d == StDrive);
      busy        <= (state_d == StGap);
      sel_err     <= err_d;
    end
  end

endmodule

// File: tb/tb_bus_dec.sv
// Self-checking bench for bus_dec: directed steps plus a random request stream, with a
// reference model feeding a scoreboard queue.
module tb_bus_dec;

  logic        clk;
  logic        clr;
  logic        sel_valid;
  logic [4:0]  sel;
  logic        err_clr;
  logic [23:0] out_en;
  logic [4:0]  active_code;
  logic        drive;
  logic        busy;
  logic        sel_err;

  bus_dec dut (
    .clk         (clk),
    .clr         (clr),
    .sel_valid   (sel_valid),
    .sel         (sel),
    .err_clr     (err_clr),
    .out_en      (out_en),
    .active_code (active_code),
    .drive       (drive),
    .busy        (busy),
    .sel_err     (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] oe;
    logic [4:0]  code;
    logic        drv;
    logic        bsy;
    logic        err;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 idle, 1 driving, 2 gap.
  int          m_state = 0;
  logic [4:0]  m_code  = '0;
  logic        m_err   = 1'b0;
  logic [23:0] prev_oe = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_code  = '0;
    m_err   = 1'b0;
    prev_oe = '0;
  endtask

  task automatic model_step(input logic v, input logic [4:0] s, input logic ec);
    logic ok;
    exp_t e;
    ok = (s <= 5'd23);
    if (v && !ok)  m_err = 1'b1;
    else if (ec)   m_err = 1'b0;
    if (m_state == 0) begin
      if (v && ok) begin m_state = 1; m_code = s; end
    end else if (m_state == 1) begin
      if (!(v && ok))      m_state = 0;
      else if (s != m_code) m_state = 2;
    end else begin
      if (v && ok) begin m_state = 1; m_code = s; end
      else m_state = 0;
    end
    e.oe   = (m_state == 1) ? (24'h1 << m_code) : 24'h0;
    e.code = m_code;
    e.drv  = (m_state == 1);
    e.bsy  = (m_state == 2);
    e.err  = m_err;
    sb.push_back(e);
  endtask

  // Drive one request, advance one edge, then compare outputs with the scoreboard.
  task automatic step(input logic v, input logic [4:0] s, input logic ec);
    exp_t e;
    sel_valid = v;
    sel       = s;
    err_clr   = ec;
    model_step(v, s, ec);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("out_en", 32'(out_en), 32'(e.oe));
    chk("drive", 32'(drive), 32'(e.drv));
    chk("busy", 32'(busy), 32'(e.bsy));
    chk("sel_err", 32'(sel_err), 32'(e.err));
    if (e.drv) chk("active_code", 32'(active_code), 32'(e.code));
    chk("onehot_pop", 32'($countones(out_en) <= 1), 32'(1));
    chk("drive_eq_or", 32'(drive), 32'(|out_en));
    if (prev_oe != 24'h0 && out_en != 24'h0) chk("adjacent", 32'(out_en), 32'(prev_oe));
    prev_oe = out_en;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_en"}, 32'(out_en), 32'h0);
    chk({tag, "_drive"}, 32'(drive), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_code"}, 32'(active_code), 32'h0);
    chk({tag, "_err"}, 32'(sel_err), 32'h0);
  endtask

  initial begin
    logic        rv;
    logic [4:0]  rs;
    logic        rc;
    clr       = 1'b1;
    sel_valid = 1'b0;
    sel       = '0;
    err_clr   = 1'b0;
    model_reset();
    #12;
    chk_reset_outputs("reset");
    #1 clr = 1'b0;
    @(posedge clk);
    #1;

    // Single source, one-cycle latency.
    step(1'b1, 5'd7, 1'b0);
    chk("d7_out_en", 32'(out_en), 32'h000080);
    chk("d7_drive", 32'(drive), 32'h1);
    chk("d7_code", 32'(active_code), 32'd7);

    // Source change inserts one gap cycle.
    step(1'b1, 5'd23, 1'b0);
    chk("gap_out_en", 32'(out_en), 32'h0);
    chk("gap_busy", 32'(busy), 32'h1);
    step(1'b1, 5'd23, 1'b0);
    chk("d23_out_en", 32'(out_en), 32'h800000);
    step(1'b0, 5'd0, 1'b0);

    // Sticky error: set wins over clear in the same cycle.
    step(1'b1, 5'd30, 1'b0);
    chk("e30_out_en", 32'(out_en), 32'h0);
    chk("e30_err", 32'(sel_err), 32'h1);
    step(1'b1, 5'd25, 1'b1);
    chk("e25_err", 32'(sel_err), 32'h1);
    step(1'b0, 5'd0, 1'b1);
    chk("eclr_err", 32'(sel_err), 32'h0);

    // Retarget during the gap: last request wins.
    step(1'b1, 5'd5, 1'b0);
    step(1'b1, 5'd2, 1'b0);
    chk("rt_busy", 32'(busy), 32'h1);
    step(1'b1, 5'd4, 1'b0);
    chk("rt_out_en", 32'(out_en), 32'h000010);

    // Dropping the request in the gap discards it.
    step(1'b1, 5'd2, 1'b0);
    step(1'b0, 5'd2, 1'b0);
    chk("drop_out_en", 32'(out_en), 32'h0);

    // Invalid code while driving returns to idle with an error.
    step(1'b1, 5'd4, 1'b0);
    step(1'b1, 5'd31, 1'b0);
    chk("inv_drive", 32'(drive), 32'h0);
    chk("inv_err", 32'(sel_err), 32'h1);
    step(1'b0, 5'd0, 1'b1);

    // Asynchronous reset while driving code 0.
    step(1'b1, 5'd0, 1'b0);
    chk("c0_out_en", 32'(out_en), 32'h000001);
    #3 clr = 1'b1;
    #1;
    chk_reset_outputs("async");
    model_reset();
    sb.delete();
    #1 clr = 1'b0;
    step(1'b1, 5'd3, 1'b0);
    chk("post_rst_out_en", 32'(out_en), 32'h000008);

    // Random request stream.
    rs = 5'd0;
    for (int i = 0; i < 10000; i++) begin
      rv = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 7) == 0) rs = 5'($urandom_range(24, 31));
        else                           rs = 5'($urandom_range(0, 23));
      end
      rc = ($urandom_range(0, 9) == 0);
      step(rv, rs, rc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_dec.md
BUS_DEC -- requirements
Module: bus_dec

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The module SHALL have the port clr, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The module SHALL have the port sel_valid, input, 1 bit: the requester wants a source driving the bus this cycle.
REQ-004 The module SHALL have the port sel, input, 5 bits: requested source code, valid range 0..23.
REQ-005 The module SHALL have the port err_clr, input, 1 bit: synchronous clear of sel_err.
REQ-006 The module SHALL have the port out_en, output, 24 bits: one-hot source drive enables; bit i enables the source with code i.
REQ-007 The module SHALL have the port active_code, output, 5 bits: code currently driving; meaningful only when drive=1.
REQ-008 The module SHALL have the port drive, output, 1 bit: high exactly when out_en is nonzero.
REQ-009 The module SHALL have the port busy, output, 1 bit: high during the turnaround gap cycle.
REQ-010 The module SHALL have the port sel_err, output, 1 bit: sticky flag set by an out-of-range code request.

Function
REQ-011 Source code map SHALL be: 0 Cout, 1 InPortout, 2 MDRout, 3 PCout, 4 ZLowout, 5 ZHighout, 6 LOout, 7 HIout, 8..23 R15out..R0out (code 23-n = Rn).
REQ-012 out_en, drive, busy and active_code SHALL be registered outputs; a request sampled at edge k takes effect at the outputs after edge k (1-cycle latency).
REQ-013 FSM states SHALL be IDLE, DRIVE and GAP.
REQ-014 In IDLE and GAP, out_en SHALL be all zeros; in DRIVE, out_en SHALL be exactly one-hot at bit active_code.
REQ-015 IDLE transitions: sel_valid=1 with sel<24 SHALL go to DRIVE with active_code=sel; sel_valid=1 with sel>=24 SHALL stay IDLE and set sel_err; sel_valid=0 SHALL stay IDLE.
REQ-016 DRIVE transitions: sel_valid=1 with sel==active_code SHALL stay DRIVE.
REQ-017 DRIVE transitions: sel_valid=1 with a valid sel!=active_code SHALL go to GAP and latch pending=sel.
REQ-018 DRIVE transitions: sel_valid=0 SHALL go to IDLE.
REQ-019 DRIVE transitions: sel_valid=1 with sel>=24 SHALL go to IDLE and set sel_err.
REQ-020 GAP SHALL last exactly one cycle (break-before-make: no two sources are ever enabled on adjacent cycles).
REQ-021 In GAP, sel_valid=1 with a valid sel SHALL overwrite pending (last request wins); the next state SHALL be DRIVE with active_code=pending.
REQ-022 In GAP, sel_valid=0 SHALL go to IDLE, and the pending request SHALL be discarded.
REQ-023 In GAP, an invalid sel SHALL go to IDLE and set sel_err.
REQ-024 busy SHALL equal (state==GAP); drive SHALL equal (state==DRIVE).
REQ-025 sel_err SHALL be set by any cycle with sel_valid=1 and sel>=24, and cleared by err_clr=1; when both occur in the same cycle, set wins.
REQ-026 An invalid code SHALL never produce a nonzero out_en.

Reset
REQ-027 clr=1 SHALL immediately force state IDLE, out_en=0, drive=0, busy=0, active_code=0, pending=0 and sel_err=0, independent of clk.
REQ-028 Reset asserted mid-DRIVE or mid-GAP SHALL drop out_en to zero without waiting for an edge.
REQ-029 On the first edge after clr deasserts, requests SHALL be handled as from IDLE.

Structure
REQ-030 A shared package bus_pkg SHALL hold NUM_SRC=24, the named source-code constants CODE_COUT..CODE_R0 and the state enum.
REQ-031 The one-hot expansion of a 5-bit code to 24 bits SHALL be a sub-module onehot24_dec, which outputs zero for codes >=24.
REQ-032 The FSM, pending register and error flag SHALL live in bus_dec.

Verification
REQ-033 The bench SHALL reset, then hold sel_valid=1, sel=7 -> after 1 edge out_en=24'h000080, drive=1, active_code=7.
REQ-034 The bench SHALL drive sel 7 then 23 on consecutive cycles -> one GAP cycle with out_en=0 and busy=1, then out_en=24'h800000.
REQ-035 The bench SHALL drive sel=30 from IDLE -> out_en stays 0 and sel_err=1; then err_clr=1 together with sel=25 -> sel_err stays 1; then err_clr=1 alone -> sel_err=0.
REQ-036 The bench SHALL, during GAP toward code 2, change sel to 4 -> the next DRIVE has out_en=24'h000010.
REQ-037 The bench SHALL assert clr asynchronously mid-DRIVE on code 0 -> out_en=0 before the next edge; all outputs at reset values.
REQ-038 The bench SHALL use a randomized request stream for 10k cycles with assertions: popcount(out_en)<=1, no two distinct nonzero out_en values on adjacent cycles, and drive==|out_en.
